// File: rtl/pcie_rx_symbol_aligner.sv
// rtl/pcie_rx_symbol_aligner.sv - per-lane 8b/10b RX COM hunt, symbol lock and symbol alignment
//
// Takes one serial bit per cycle, hunts for K28.5 (either disparity), acquires lock after
// LOCK_COM_COUNT aligned COMs and presents aligned 10-bit symbols while locked.
//
// Ports:
//   clk_i            single clock
//   rst_i            asynchronous active-high reset
//   lane_enable_i    low = synchronous clear back to UNLOCKED
//   rx_bit_i         serial bit, sampled when rx_bit_valid_i is high
//   rx_bit_valid_i   qualifies rx_bit_i
//   symbol_o         aligned symbol, bit0 = first received bit
//   symbol_valid_o   one-cycle pulse per aligned symbol (locked only)
//   symbol_is_com_o  symbol_o is a COM, qualified by symbol_valid_o
//   symbol_lock_o    high while locked
//   align_err_o      one-cycle pulse per misaligned COM seen while locked
module pcie_rx_symbol_aligner #(
    parameter logic [9:0] COM_RD_NEG       = 10'h17C,
    parameter logic [9:0] COM_RD_POS       = 10'h283,
    parameter int         LOCK_COM_COUNT   = 2,
    parameter int         UNLOCK_ERR_COUNT = 4,
    parameter int         CHECK_TIMEOUT    = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       lane_enable_i,
    input  logic       rx_bit_i,
    input  logic       rx_bit_valid_i,
    output logic [9:0] symbol_o,
    output logic       symbol_valid_o,
    output logic       symbol_is_com_o,
    output logic       symbol_lock_o,
    output logic       align_err_o
);

    localparam int COM_W = $clog2(LOCK_COM_COUNT + 1);
    localparam int ERR_W = $clog2(UNLOCK_ERR_COUNT + 1);
    localparam int TMO_W = $clog2(CHECK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_CHECK,
        ST_LOCKED
    } state_t;

    state_t             state_q, state_d;
    logic [9:0]         sr_q, sr_d;
    logic [3:0]         phase_q, phase_d;
    logic [COM_W-1:0]   com_cnt_q, com_cnt_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [9:0]         symbol_q, symbol_d;
    logic               symbol_valid_q, symbol_valid_d;
    logic               symbol_is_com_q, symbol_is_com_d;
    logic               symbol_lock_q, symbol_lock_d;
    logic               align_err_q, align_err_d;

    logic [9:0]         sr_n;
    logic               match;
    logic               boundary;

    assign sr_n     = {rx_bit_i, sr_q[9:1]};
    assign match    = (sr_n == COM_RD_NEG) || (sr_n == COM_RD_POS);
    assign boundary = (phase_q == 4'd9);

    always_comb begin
        state_d         = state_q;
        sr_d            = sr_q;
        phase_d         = phase_q;
        com_cnt_d       = com_cnt_q;
        err_cnt_d       = err_cnt_q;
        tmo_cnt_d       = tmo_cnt_q;
        symbol_d        = symbol_q;
        symbol_is_com_d = symbol_is_com_q;
        symbol_valid_d  = 1'b0;
        align_err_d     = 1'b0;

        if (!lane_enable_i) begin
            state_d         = ST_UNLOCKED;
            sr_d            = '0;
            phase_d         = '0;
            com_cnt_d       = '0;
            err_cnt_d       = '0;
            tmo_cnt_d       = '0;
            symbol_d        = '0;
            symbol_is_com_d = 1'b0;
        end else if (rx_bit_valid_i) begin
            sr_d    = sr_n;
            phase_d = boundary ? 4'd0 : phase_q + 4'd1;

            case (state_q)
                ST_UNLOCKED: begin
                    if (match) begin
                        // The COM just completed defines the symbol grid: next bit is phase 0.
                        phase_d   = '0;
                        com_cnt_d = COM_W'(1);
                        tmo_cnt_d = '0;
                        if (LOCK_COM_COUNT <= 1) begin
                            state_d         = ST_LOCKED;
                            err_cnt_d       = '0;
                            symbol_d        = sr_n;
                            symbol_is_com_d = 1'b1;
                            symbol_valid_d  = 1'b1;
                        end else begin
                            state_d = ST_CHECK;
                        end
                    end
                end

                ST_CHECK: begin
                    if (match && !boundary) begin
                        phase_d   = '0;
                        com_cnt_d = COM_W'(1);
                        tmo_cnt_d = '0;
                    end else if (match) begin
                        tmo_cnt_d = '0;
                        if (int'(com_cnt_q) + 1 >= LOCK_COM_COUNT) begin
                            state_d         = ST_LOCKED;
                            com_cnt_d       = COM_W'(LOCK_COM_COUNT);
                            err_cnt_d       = '0;
                            symbol_d        = sr_n;
                            symbol_is_com_d = 1'b1;
                            symbol_valid_d  = 1'b1;
                        end else begin
                            com_cnt_d = com_cnt_q + COM_W'(1);
                        end
                    end else if (boundary) begin
                        if (int'(tmo_cnt_q) + 1 >= CHECK_TIMEOUT) begin
                            state_d   = ST_UNLOCKED;
                            com_cnt_d = '0;
                            tmo_cnt_d = '0;
                            err_cnt_d = '0;
                        end else begin
                            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                        end
                    end
                end

                ST_LOCKED: begin
                    if (boundary) begin
                        symbol_d        = sr_n;
                        symbol_is_com_d = match;
                        symbol_valid_d  = 1'b1;
                        if (match) begin
                            err_cnt_d = '0;
                        end
                    end else if (match) begin
                        // Misaligned COM: keep the current grid, only count it.
                        align_err_d = 1'b1;
                        if (int'(err_cnt_q) + 1 >= UNLOCK_ERR_COUNT) begin
                            state_d   = ST_UNLOCKED;
                            com_cnt_d = '0;
                            tmo_cnt_d = '0;
                            err_cnt_d = '0;
                        end else begin
                            err_cnt_d = err_cnt_q + ERR_W'(1);
                        end
                    end
                end

                default: state_d = ST_UNLOCKED;
            endcase
        end

        symbol_lock_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= ST_UNLOCKED;
            sr_q            <= '0;
            phase_q         <= '0;
            com_cnt_q       <= '0;
            err_cnt_q       <= '0;
            tmo_cnt_q       <= '0;
            symbol_q        <= '0;
            symbol_valid_q  <= 1'b0;
            symbol_is_com_q <= 1'b0;
            symbol_lock_q   <= 1'b0;
            align_err_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            sr_q            <= sr_d;
            phase_q         <= phase_d;
            com_cnt_q       <= com_cnt_d;
            err_cnt_q       <= err_cnt_d;
            tmo_cnt_q       <= tmo_cnt_d;
            symbol_q        <= symbol_d;
            symbol_valid_q  <= symbol_valid_d;
            symbol_is_com_q <= symbol_is_com_d;
            symbol_lock_q   <= symbol_lock_d;
            align_err_q     <= align_err_d;
        end
    end

    assign symbol_o        = symbol_q;
    assign symbol_valid_o  = symbol_valid_q;
    assign symbol_is_com_o = symbol_is_com_q;
    assign symbol_lock_o   = symbol_lock_q;
    assign align_err_o     = align_err_q;

endmodule

// File: tb/tb_pcie_rx_symbol_aligner.sv
// tb/tb_pcie_rx_symbol_aligner.sv - scoreboard bench for pcie_rx_symbol_aligner
module tb_pcie_rx_symbol_aligner;

    localparam logic [9:0] COM_N = 10'h17C;
    localparam logic [9:0] COM_P = 10'h283;
    localparam logic [9:0] D_A   = 10'h2AA;
    localparam logic [9:0] D_B   = 10'h0B9;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       lane_enable_i;
    logic       rx_bit_i;
    logic       rx_bit_valid_i;
    logic [9:0] symbol_o;
    logic       symbol_valid_o;
    logic       symbol_is_com_o;
    logic       symbol_lock_o;
    logic       align_err_o;

    pcie_rx_symbol_aligner dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .lane_enable_i   (lane_enable_i),
        .rx_bit_i        (rx_bit_i),
        .rx_bit_valid_i  (rx_bit_valid_i),
        .symbol_o        (symbol_o),
        .symbol_valid_o  (symbol_valid_o),
        .symbol_is_com_o (symbol_is_com_o),
        .symbol_lock_o   (symbol_lock_o),
        .align_err_o     (align_err_o)
    );

    always #5 clk_i = ~clk_i;

    int          total = 0;
    int          bad   = 0;
    logic [10:0] exp_q[$];
    logic [10:0] mon_e;
    logic [9:0]  tb_sr = '0;
    int          tb_phase = 0;
    bit          exp_on = 1'b0;
    bit          gap_mode = 1'b0;
    int          gap_ctr = 0;
    int          err_seen = 0;
    int          e0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every symbol pulse must match the oldest expected symbol.
    always @(negedge clk_i) begin
        if (align_err_o === 1'b1) err_seen++;
        if (symbol_valid_o !== 1'b0) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_symbol: got %0h with none expected", symbol_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("symbol", {21'd0, symbol_is_com_o, symbol_o}, {21'd0, mon_e});
            end
        end
    end

    task automatic send_bit(input logic b);
        if (gap_mode) begin
            gap_ctr++;
            if (gap_ctr == 3) begin
                gap_ctr = 0;
                rx_bit_valid_i = 1'b0;
                @(posedge clk_i);
                #1;
            end
        end
        rx_bit_i       = b;
        rx_bit_valid_i = 1'b1;
        tb_sr = {b, tb_sr[9:1]};
        if (exp_on && tb_phase == 9)
            exp_q.push_back({(tb_sr == COM_N) || (tb_sr == COM_P), tb_sr});
        tb_phase = (tb_phase == 9) ? 0 : tb_phase + 1;
        @(posedge clk_i);
        #1;
        rx_bit_valid_i = 1'b0;
    endtask

    task automatic send_sym(input logic [9:0] s);
        for (int i = 0; i < 10; i++) send_bit(s[i]);
    endtask

    task automatic send_fill5();
        logic [4:0] f;
        f = 5'b01010;
        for (int i = 0; i < 5; i++) send_bit(f[i]);
    endtask

    task automatic idle(input int n);
        rx_bit_valid_i = 1'b0;
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic lane_clear();
        lane_enable_i  = 1'b0;
        rx_bit_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        lane_enable_i  = 1'b1;
        rx_bit_valid_i = 1'b0;
    endtask

    // COM, n data symbols, COM: lock must appear exactly on the second aligned COM.
    task automatic acquire_lock(input int n);
        exp_on = 1'b0;
        send_sym(COM_N);
        tb_phase = 0;
        check("lock_after_1st_com", {31'd0, symbol_lock_o}, 32'd0);
        repeat (n) send_sym(D_A);
        check("lock_before_2nd_com", {31'd0, symbol_lock_o}, 32'd0);
        exp_on = 1'b1;
        send_sym(COM_P);
        check("lock_after_2nd_com", {31'd0, symbol_lock_o}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_i          = 1'b1;
        lane_enable_i  = 1'b1;
        rx_bit_i       = 1'b0;
        rx_bit_valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_symbol",  {22'd0, symbol_o},        32'd0);
        check("rst_valid",   {31'd0, symbol_valid_o},  32'd0);
        check("rst_is_com",  {31'd0, symbol_is_com_o}, 32'd0);
        check("rst_lock",    {31'd0, symbol_lock_o},   32'd0);
        check("rst_err",     {31'd0, align_err_o},     32'd0);
        rst_i = 1'b0;

        // 1: no COM in 200 bits
        repeat (20) send_sym(D_A);
        check("t1_no_lock", {31'd0, symbol_lock_o}, 32'd0);

        // 2: junk, COM, 9 data, COM -> lock, then payload
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        acquire_lock(9);
        repeat (4) send_sym(D_B);
        idle(2);
        check("t2_queue_empty", exp_q.size(), 32'd0);

        // 3: same stream with gaps
        exp_on = 1'b0;
        lane_clear();
        gap_mode = 1'b1;
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        acquire_lock(9);
        repeat (4) send_sym(D_B);
        gap_mode = 1'b0;
        idle(2);
        check("t3_queue_empty", exp_q.size(), 32'd0);

        // 4a: four misaligned COMs drop lock
        e0 = err_seen;
        for (int k = 0; k < 4; k++) begin
            send_fill5();
            send_sym(COM_N);
            if (k == 2) check("t4_lock_after_3", {31'd0, symbol_lock_o}, 32'd1);
            if (k == 3) begin
                check("t4_unlock_after_4", {31'd0, symbol_lock_o}, 32'd0);
                exp_on = 1'b0;
            end
            send_fill5();
        end
        check("t4_err_pulses", err_seen - e0, 32'd4);

        // 4b: an aligned COM between misaligned ones clears the error count
        acquire_lock(1);
        e0 = err_seen;
        for (int k = 0; k < 7; k++) begin
            if (k == 3) begin
                send_sym(COM_N);
            end else begin
                send_fill5();
                send_sym(COM_N);
                send_fill5();
            end
        end
        check("t4_lock_held", {31'd0, symbol_lock_o}, 32'd1);
        check("t4_err_pulses_b", err_seen - e0, 32'd6);
        send_sym(D_B);
        idle(2);
        check("t4_queue_empty", exp_q.size(), 32'd0);

        // 5: CHECK timeout after 32 boundaries; 31 still locks
        exp_on = 1'b0;
        lane_clear();
        send_sym(COM_N);
        tb_phase = 0;
        repeat (32) send_sym(D_A);
        check("t5_no_lock_timeout", {31'd0, symbol_lock_o}, 32'd0);
        acquire_lock(1);
        exp_on = 1'b0;
        lane_clear();
        acquire_lock(31);

        // 6a: async reset mid-symbol
        send_sym(D_B);
        exp_on = 1'b0;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        #2 rst_i = 1'b1;
        #1;
        check("t6_rst_lock",   {31'd0, symbol_lock_o},  32'd0);
        check("t6_rst_symbol", {22'd0, symbol_o},       32'd0);
        check("t6_rst_valid",  {31'd0, symbol_valid_o}, 32'd0);
        #2 rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        acquire_lock(1);

        // 6b: lane disable for one cycle
        send_sym(D_B);
        exp_on = 1'b0;
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        lane_clear();
        check("t6_dis_lock",   {31'd0, symbol_lock_o},   32'd0);
        check("t6_dis_symbol", {22'd0, symbol_o},        32'd0);
        check("t6_dis_is_com", {31'd0, symbol_is_com_o}, 32'd0);
        acquire_lock(1);
        send_sym(D_B);
        idle(3);
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
